// File: rtl/mem_access_arbiter_pkg.sv
// Shared state codes, owner codes and the round-robin grant helper for the
// memory access arbiter.
package mem_access_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_e;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // On contention the requester that did not win last time is chosen.
   function automatic logic pick_owner(input logic if_req,
                                       input logic d_req,
                                       input logic last_grant);
      logic owner;
      if (if_req && d_req) begin
         owner = ~last_grant;
      end else if (d_req) begin
         owner = REQ_D;
      end else begin
         owner = REQ_IF;
      end
      return owner;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_wait_counter.sv
// Loadable down-counter that times how long the memory enable is held.
module mem_wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Counter register: load has priority, decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {W{1'b0}})) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// holding each access for MEM_LATENCY cycles and returning a one-cycle ack.
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   arb_state_e        state_r, state_s;
   logic              owner_r, owner_s;
   logic              last_grant_r, last_grant_s;
   logic              mem_en_r, mem_en_s;
   logic              mem_we_r, mem_we_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
   logic [DATA_W-1:0] rdata_r, rdata_s;
   logic              if_ack_r, if_ack_s;
   logic              d_ack_r, d_ack_s;
   logic              busy_r, busy_s;
   logic              grant_s;
   logic              cnt_load_s, cnt_dec_s, cnt_zero_s;

   mem_wait_counter #(.W(CNT_W)) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load_s),
      .load_val (CNT_LOAD),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s      = state_r;
      owner_s      = owner_r;
      last_grant_s = last_grant_r;
      mem_en_s     = mem_en_r;
      mem_we_s     = mem_we_r;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      rdata_s      = rdata_r;
      if_ack_s     = 1'b0;
      d_ack_s      = 1'b0;
      cnt_load_s   = 1'b0;
      cnt_dec_s    = 1'b0;
      grant_s      = pick_owner(if_req, d_req, last_grant_r);
      case (state_r)
         ARB_IDLE: begin
            if (if_req || d_req) begin
               state_s      = ARB_ACCESS;
               owner_s      = grant_s;
               last_grant_s = grant_s;
               mem_en_s     = 1'b1;
               cnt_load_s   = 1'b1;
               if (grant_s == REQ_D) begin
                  mem_we_s    = d_we;
                  mem_addr_s  = d_addr;
                  mem_wdata_s = d_wdata;
               end else begin
                  mem_we_s    = 1'b0;
                  mem_addr_s  = if_addr;
                  mem_wdata_s = {DATA_W{1'b0}};
               end
            end else begin
               state_s = ARB_IDLE;
            end
         end
         ARB_ACCESS: begin
            if (cnt_zero_s) begin
               state_s  = ARB_DONE;
               mem_en_s = 1'b0;
               mem_we_s = 1'b0;
               if (!mem_we_r) begin
                  rdata_s = mem_rdata;
               end else begin
                  rdata_s = rdata_r;
               end
               if (owner_r == REQ_IF) begin
                  if_ack_s = 1'b1;
               end else begin
                  d_ack_s = 1'b1;
               end
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         ARB_DONE: begin
            state_s = ARB_IDLE;
         end
         default: begin
            state_s  = ARB_IDLE;
            mem_en_s = 1'b0;
            mem_we_s = 1'b0;
         end
      endcase
      busy_s = (state_s != ARB_IDLE);
   end

   // State and output registers; reset abandons any access without an ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ARB_IDLE;
         owner_r      <= REQ_IF;
         last_grant_r <= REQ_D;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {DATA_W{1'b0}};
         rdata_r      <= {DATA_W{1'b0}};
         if_ack_r     <= 1'b0;
         d_ack_r      <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         owner_r      <= owner_s;
         last_grant_r <= last_grant_s;
         mem_en_r     <= mem_en_s;
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
         rdata_r      <= rdata_s;
         if_ack_r     <= if_ack_s;
         d_ack_r      <= d_ack_s;
         busy_r       <= busy_s;
      end
   end

   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_ack    = if_ack_r;
   assign d_ack     = d_ack_r;
   assign if_rdata  = rdata_r;
   assign d_rdata   = rdata_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed vector table, corner
// sequences and a randomized run against a timeline reference model.
module tb_mem_access_arbiter;

   localparam int LAT = 2;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        exp_is_if;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_ack, d_ack, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        u1_if_req;
   logic [31:0] u1_if_addr;
   logic        u1_if_ack, u1_d_ack, u1_mem_en, u1_mem_we, u1_busy;
   logic [31:0] u1_if_rdata, u1_d_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

   logic [31:0] mem [256];
   int n_cmp = 0;
   int n_bad = 0;

   mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_lat1 (
      .clk(clk), .reset(reset),
      .if_req(u1_if_req), .if_addr(u1_if_addr), .if_ack(u1_if_ack), .if_rdata(u1_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ack(u1_d_ack), .d_rdata(u1_d_rdata),
      .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
      .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata), .busy(u1_busy)
   );

   function automatic logic [31:0] mem_init(input int i);
      return (i == 64) ? 32'h00500093 : (32'hA5000000 | 32'(i));
   endfunction

   // Word-addressed memory, reloaded on reset, written by the main DUT.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      end else if (mem_en && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   assign mem_rdata    = mem_en ? mem[mem_addr[9:2]] : 32'h0;
   assign u1_mem_rdata = u1_mem_en ? mem[u1_mem_addr[9:2]] : 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      u1_if_req = 1'b0; u1_if_addr = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      if_req = v.if_req; if_addr = v.if_addr;
      d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
      @(negedge clk);
      check("txn_idle_busy", {63'h0, busy}, 64'h0);
      check("txn_idle_en", {63'h0, mem_en}, 64'h0);
      for (int k = 1; k <= LAT + 1; k++) begin
         next_cycle();
         @(negedge clk);
         if (k <= LAT) begin
            check("txn_en", {63'h0, mem_en}, 64'h1);
            check("txn_we", {63'h0, mem_we}, {63'h0, v.exp_we});
            check("txn_addr", {32'h0, mem_addr}, {32'h0, v.exp_addr});
            check("txn_wdata", {32'h0, mem_wdata}, {32'h0, v.exp_wdata});
            check("txn_acks_early", {62'h0, if_ack, d_ack}, 64'h0);
         end else begin
            check("txn_done_en_we", {62'h0, mem_en, mem_we}, 64'h0);
            check("txn_if_ack", {63'h0, if_ack}, {63'h0, v.exp_is_if});
            check("txn_d_ack", {63'h0, d_ack}, {63'h0, ~v.exp_is_if});
            check("txn_if_rdata", {32'h0, if_rdata}, {32'h0, v.exp_rdata});
            check("txn_d_rdata", {32'h0, d_rdata}, {32'h0, v.exp_rdata});
         end
      end
      next_cycle();
      if_req = 1'b0; d_req = 1'b0;
   endtask

   vec_t vecs [7];

   int          free_at, grant_c, ack_c;
   logic        m_owner, m_last, m_we, if_pend, d_pend, if_seen, d_seen, in_acc;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [31:0] ref_mem [256];
   logic [7:0]  idx;

   initial begin
      vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        32'h00500093};
      vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 32'h00500093};
      vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h104, 32'h0,        32'hA5000041};
      vecs[4] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h300, 32'h12345678, 1'b0, 1'b1, 32'h300, 32'h12345678, 32'hA5000041};
      vecs[5] = '{1'b1, 32'h10C, 1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 1'b0, 32'h10C, 32'h0,        32'hA5000043};
      vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h300, 32'h0,        1'b0, 1'b0, 32'h300, 32'h0,        32'h12345678};

      do_reset();
      @(negedge clk);
      check("rst_outputs", {57'h0, mem_en, mem_we, if_ack, d_ack, busy, 2'b00}, 64'h0);
      check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
      check("rst_rdata", {if_rdata, d_rdata}, 64'h0);

      // Single-cycle-latency build: ack two cycles after the request.
      next_cycle();
      u1_if_req = 1'b1; u1_if_addr = 32'h100;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         if (c == 3) u1_if_req = 1'b0;
         @(negedge clk);
         check("lat1_en", {63'h0, u1_mem_en}, {63'h0, (c == 1)});
         check("lat1_ack", {63'h0, u1_if_ack}, {63'h0, (c == 2)});
         check("lat1_busy", {63'h0, u1_busy}, {63'h0, (c == 1 || c == 2)});
         check("lat1_d_ack_we", {62'h0, u1_d_ack, u1_mem_we}, 64'h0);
         if (c == 1) check("lat1_addr", {u1_mem_wdata, u1_mem_addr}, 64'h100);
         if (c == 2) check("lat1_rdata", {u1_d_rdata, u1_if_rdata}, {32'h00500093, 32'h00500093});
      end
      next_cycle();

      foreach (vecs[i]) run_txn(vecs[i]);

      // Request withdrawn and address changed right after the grant.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         d_req = 1'b0; d_addr = 32'h3FC;
         @(negedge clk);
         check("wd_en", {63'h0, mem_en}, {63'h0, (c <= 2)});
         if (c <= 2) check("wd_addr", {32'h0, mem_addr}, 64'h100);
         check("wd_ack", {63'h0, d_ack}, {63'h0, (c == 3)});
         if (c == 3) check("wd_rdata", {32'h0, d_rdata}, 64'h00500093);
      end
      next_cycle();

      // Continuous contention after reset: IF, D, IF, D.
      do_reset();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check("tie_if_ack", {63'h0, if_ack}, {63'h0, (c == 3 || c == 11)});
         check("tie_d_ack", {63'h0, d_ack}, {63'h0, (c == 7 || c == 15)});
         if ((c % 4 == 1) || (c % 4 == 2))
            check("tie_addr", {32'h0, mem_addr}, ((c / 4) % 2 == 0) ? 64'h100 : 64'h200);
      end
      next_cycle();
      if_req = 1'b0; d_req = 1'b0;

      // Reset in the first access cycle of a load.
      next_cycle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("rma_en_before", {63'h0, mem_en}, 64'h1);
      next_cycle();
      reset = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("rma_outputs", {57'h0, mem_en, mem_we, if_ack, d_ack, busy, 2'b00}, 64'h0);
      check("rma_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
      check("rma_rdata", {if_rdata, d_rdata}, 64'h0);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         @(negedge clk);
         check("rma_no_ack", {62'h0, d_ack, mem_en}, 64'h0);
      end

      // Randomized traffic against a cycle-timeline model.
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
      free_at = 0; grant_c = -100; ack_c = -100; m_last = 1'b1;
      m_owner = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
      if_pend = 1'b0; d_pend = 1'b0; if_seen = 1'b0; d_seen = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         next_cycle();
         if (if_seen) if_pend = 1'b0;
         if (d_seen) d_pend = 1'b0;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            idx = 8'($urandom_range(0, 255));
            if_addr = {22'h0, idx, 2'b00};
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1;
            idx = 8'($urandom_range(0, 255));
            d_addr = {22'h0, idx, 2'b00};
            d_we = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
         end
         if_req = if_pend; d_req = d_pend;
         if (c >= free_at && (if_pend || d_pend)) begin
            m_owner = (if_pend && d_pend) ? ~m_last : d_pend;
            m_last = m_owner;
            grant_c = c; ack_c = c + LAT + 1; free_at = c + LAT + 2;
            m_addr = m_owner ? d_addr : if_addr;
            m_we = m_owner ? d_we : 1'b0;
            m_wdata = m_owner ? d_wdata : 32'h0;
            if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
            else m_rdata = ref_mem[m_addr[9:2]];
         end
         @(negedge clk);
         in_acc = (c > grant_c) && (c <= grant_c + LAT);
         check("rnd_en", {63'h0, mem_en}, {63'h0, in_acc});
         check("rnd_we", {63'h0, mem_we}, {63'h0, in_acc && m_we});
         if (in_acc) check("rnd_addr_wdata", {mem_addr, mem_wdata}, {m_addr, m_wdata});
         check("rnd_if_ack", {63'h0, if_ack}, {63'h0, (c == ack_c) && !m_owner});
         check("rnd_d_ack", {63'h0, d_ack}, {63'h0, (c == ack_c) && m_owner});
         check("rnd_busy", {63'h0, busy}, {63'h0, (c > grant_c) && (c <= ack_c)});
         if (c == ack_c) check("rnd_rdata", {if_rdata, d_rdata}, {m_rdata, m_rdata});
         if_seen = if_ack; d_seen = d_ack;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
